// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU/mux
// select codes and the controller state enumeration (also used by the ALU decoder).
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_ERROR  = 4'd13
    } state_t;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: Moore-style FSM whose outputs come from the
// registered state, with memReady gating only the memory-completion strobes.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSrc,
    output logic       instrDone,
    output logic       illegalOp
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_ERROR;
                endcase
            end
            // opcode is re-sampled here; anything but LW/SW is treated as illegal
            S_MEMADR: begin
                case (opcode)
                    OP_LW:   w_next = S_MEMRD;
                    OP_SW:   w_next = S_MEMWR;
                    default: w_next = S_ERROR;
                endcase
            end
            S_MEMRD:  w_next = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = memReady ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_B;
        aluOp       = ALUOP_ADD;
        pcSrc       = PCSRC_ALU;
        instrDone   = 1'b0;
        illegalOp   = 1'b0;
        case (r_state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                irWrite = memReady;
                pcWrite = memReady;
            end
            S_DECODE: aluSrcB = SRCB_IMM_SH;
            S_MEMADR, S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEMWB: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                instrDone = 1'b1;
            end
            S_MEMWR: begin
                memWrite  = 1'b1;
                iorD      = 1'b1;
                instrDone = memReady;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_RTYPE;
            end
            S_ALUWB: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                instrDone = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = ALUOP_SUB;
                pcWriteCond = 1'b1;
                pcSrc       = PCSRC_ALUOUT;
                instrDone   = 1'b1;
            end
            S_ADDIWB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
            end
            S_JUMP: begin
                pcWrite   = 1'b1;
                pcSrc     = PCSRC_JUMP;
                instrDone = 1'b1;
            end
            // ERROR is terminal, so the state itself is the sticky illegal flag
            S_ERROR:  illegalOp = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven check of the multicycle controller plus hand-written
// reset and illegal-opcode sequences.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       memReady = 1'b0;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, instrDone, illegalOp;
    logic [1:0] aluSrcB, aluOp, pcSrc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSrc(pcSrc),
        .instrDone(instrDone), .illegalOp(illegalOp)
    );

    logic [17:0] w_out;
    assign w_out = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                    memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSrc,
                    instrDone, illegalOp};

    function automatic logic [17:0] ex(input logic pcw, pcwc, iord, mr, mw, irw,
                                       m2r, rdst, rw, asa,
                                       input logic [1:0] asb, aop, psrc,
                                       input logic done, ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, done, ill};
    endfunction

    // Expected output words, written out by hand per state
    localparam logic [17:0] E_ZERO   = 18'd0;
    localparam logic [17:0] E_FSTALL = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_FGO    = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MRD    = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_MWSTL  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MWGO   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_BR     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
    localparam logic [17:0] E_AIEX   = E_MADR;
    localparam logic [17:0] E_AIWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0};
    localparam logic [17:0] E_ERR    = {16'd0, 1'b0, 1'b1};

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [5:0] op, input logic mr, input logic [17:0] e);
        vec_t v;
        v.op = op; v.mr = mr; v.exp = e;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [17:0] req);
        n_checks++;
        if (w_out !== req) begin
            n_errors++;
            $display("FAIL %s: got %b required %b", name, w_out, req);
        end
    endtask

    // Apply inputs just after a falling edge, check, then wait for the next falling edge
    task automatic step(input string name, input logic [5:0] op, input logic mr, input logic [17:0] req);
        opcode = op;
        memReady = mr;
        #1;
        check(name, req);
        @(negedge clk);
    endtask

    initial begin
        // R-type, opcode held garbage in EXEC to show it is ignored there
        add(R, 1, E_ZERO);   add(R, 1, E_FGO);   add(R, 1, E_DEC);
        add(BAD, 1, E_EXEC); add(BAD, 0, E_ALUWB);
        // LW with 3-cycle MEMRD stall: 8 cycles FETCH..MEMWB
        add(LW, 1, E_FGO);   add(LW, 1, E_DEC);  add(LW, 1, E_MADR);
        add(BAD, 0, E_MRD);  add(BAD, 0, E_MRD); add(BAD, 0, E_MRD);
        add(BAD, 1, E_MRD);  add(BAD, 1, E_MWB);
        // SW with 2-cycle FETCH stall and 1-cycle MEMWR stall
        add(SW, 0, E_FSTALL); add(SW, 0, E_FSTALL); add(SW, 1, E_FGO);
        add(SW, 1, E_DEC);    add(SW, 1, E_MADR);
        add(BAD, 0, E_MWSTL); add(BAD, 1, E_MWGO);
        // ADDI
        add(ADDI, 1, E_FGO); add(ADDI, 1, E_DEC); add(R, 1, E_AIEX); add(R, 1, E_AIWB);
        // BEQ then J back-to-back: done pulses 3 cycles apart
        add(BEQ, 1, E_FGO);  add(BEQ, 1, E_DEC); add(BEQ, 1, E_BR);
        add(J, 1, E_FGO);    add(J, 1, E_DEC);   add(J, 1, E_JUMP);
        // illegal opcode
        add(BAD, 1, E_FGO);  add(BAD, 1, E_DEC); add(R, 1, E_ERR);

        // Outputs forced low while held in reset
        memReady = 1'b1;
        @(negedge clk);
        #1 check("reset_hold", E_ZERO);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].op, tbl[i].mr, tbl[i].exp);

        // ERROR is terminal: 20 cycles with stimulus changing, no strobes
        for (int i = 0; i < 20; i++)
            step($sformatf("err_hold%0d", i), (i % 2) ? LW : R, i[0], E_ERR);

        // Reset clears ERROR; then LW stalled in MEMRD, reset dropped mid-cycle
        rst_n = 1'b0;
        #1 check("err_clear", E_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        step("rs_idle", LW, 1, E_ZERO);
        step("rs_fetch", LW, 1, E_FGO);
        step("rs_dec", LW, 1, E_DEC);
        step("rs_madr", LW, 1, E_MADR);
        opcode = LW;
        memReady = 1'b0;
        #1 check("rs_memrd", E_MRD);
        #2 rst_n = 1'b0;
        #1 check("rs_async", E_ZERO);
        memReady = 1'b1;
        @(posedge clk);
        #1 check("rs_held", E_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        step("rs_rel_idle", LW, 0, E_ZERO);
        step("rs_rel_fetch", LW, 0, E_FSTALL);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
